viterbi_lifo_reorder_wifi: RTL and testbench
============================================

// Module: viterbi_lifo_reorder_wifi
// PURPOSE
//  Downstream of the WiFi Viterbi traceback stage. Traceback emits each decoded block newest-bit-first.
//  This block double-buffers one block per bank (ping-pong) and re-emits it oldest-bit-first.
//  Output uses a valid/ready stream toward the descrambler/MAC RX path.
//  Traceback keeps running while the previous block drains.
// PARAMETERS
//  DEPTH  64  max bits per block (= traceback length); power of two
//  AW     6   address width, log2(DEPTH)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-low reset
//  in_valid   in   1     decoded bit valid (traceback valid_out); high for one contiguous run per block
//  in_data    in   1     decoded bit (traceback decoded_data), reverse time order
//  out_ready  in   1     consumer accepts out_data this cycle
//  out_valid  out  1     out_data valid
//  out_data   out  1     decoded bit, forward time order
//  out_last   out  1     qualifies the last bit of a block (with out_valid)
//  overflow   out  1     sticky: an input bit was dropped because both banks were full
//  busy       out  1     any bank full, or a read is in progress
// BEHAVIOUR
//  Reset: all outputs 0; wr_bank=rd_bank=0; wr_cnt=0; full[1:0]=0; len[*]=0; FSM=IDLE.
//   Memory contents are not reset.
//  Write side (no backpressure to traceback):
//   - in_valid && !full[wr_bank]: mem[wr_bank][wr_cnt]<=in_data; wr_cnt<=wr_cnt+1 (wr_cnt is AW+1 bits).
//   - Block close (a) in_valid falls (registered prev=1, now 0) with wr_cnt>0, or (b) the write that makes
//     wr_cnt==DEPTH. On close: full[wr_bank]<=1; len[wr_bank]<=count; wr_bank toggles; wr_cnt<=0.
//     Case (b) closes in the same cycle as the DEPTH-th write; a following in_valid cycle starts a new block.
//   - in_valid && full[wr_bank]: bit dropped, no write, wr_cnt unchanged; overflow<=1 (cleared by reset only).
//   - The full check uses the registered full[] value; a bank freed this cycle is writable next cycle.
//  Read side FSM (IDLE, FETCH, STREAM):
//   - IDLE: if full[rd_bank] -> FETCH; rd_ptr<=len[rd_bank]-1.
//   - FETCH: issue synchronous read of mem[rd_bank][rd_ptr]; -> STREAM next cycle with out_valid=1.
//   - STREAM: out_data=mem[rd_bank][rd_ptr]; out_last=(rd_ptr==0).
//     On out_valid&&out_ready, if rd_ptr!=0: rd_ptr-1 and present the next bit the following cycle,
//     no bubble (prefetch read).
//     On accept with rd_ptr==0: out_valid<=0; full[rd_bank]<=0; rd_bank toggles; -> IDLE.
//   - out_valid&&!out_ready: out_data/out_last held stable. out_valid never drops without acceptance.
//  Latency: first out_valid 2 cycles after the bank-close edge (IDLE->FETCH->STREAM).
//   Steady state: 1 bit/cycle while out_ready=1.
//  Simultaneous events:
//   - Write-close of one bank and read-release of the other in the same cycle: both updates apply.
//   - Close of bank X and IDLE seeing full[X]: IDLE uses the registered value (next cycle).
//  len==1: FETCH->STREAM with out_last=1 on the first bit.
//  Reset mid-block: partial block discarded, state returns to reset values.
// STRUCTURE
//  Shared package/include wifi_phy_defs: TB_DEPTH=64, TB_AW=6, FSM state encodings RD_IDLE/RD_FETCH/RD_STREAM.
//  One sub-module: reorder_dpram (2*DEPTH x 1 simple dual-port: sync write, sync read with read enable),
//   address = {bank, ptr}.
//  FSM, counters and full/len bookkeeping live in the top module.
// TESTING
//  1 Block 0..63 sent as bit(i)=i[0]^i[3], reverse order, out_ready=1 -> 64 bits forward order;
//    out_last on the 64th; first out_valid 2 cycles after the 64th input.
//  2 Short block: 10 bits, then in_valid low -> exactly 10 bits out, out_last on the 10th; len=10.
//  3 Back-to-back 64-bit blocks, out_ready=1 -> continuous output, no gaps after the first;
//    overflow stays 0; bank alternation is correct.
//  4 out_ready held 0 while 3 blocks arrive -> blocks 1 and 2 stored; block 3 bits dropped;
//    overflow=1 sticky. Releasing out_ready yields blocks 1 then 2 intact.
//  5 Random out_ready (50%) -> out_data/out_last stable while stalled; bitstream equals the reference model.
//  6 Assert reset mid-STREAM -> out_valid=0, busy=0, overflow=0 immediately. A new 64-bit block reorders correctly.
//  7 Single-bit block (in_valid one cycle) -> one output with out_last=1.

Source files
------------

// File: rtl/wifi_phy_defs_pkg.sv
// wifi_phy_defs: shared traceback sizing and reorder read-FSM encodings for the WiFi Viterbi path.
package wifi_phy_defs;
    localparam int TB_DEPTH = 64;
    localparam int TB_AW = 6;
    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;
endpackage

// File: rtl/reorder_dpram.sv
// reorder_dpram: 2*DEPTH x 1 simple dual-port RAM, sync write, sync read with read enable.
// Address is {bank, ptr}; rdata holds its value while re is low.
module reorder_dpram #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic          wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    output logic          rdata
);
    logic mem [2**(AW+1)];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/viterbi_lifo_reorder_wifi.sv
// viterbi_lifo_reorder_wifi: ping-pong buffers newest-first traceback blocks and streams them
// oldest-first over valid/ready; bits arriving while both banks are full are dropped.
module viterbi_lifo_reorder_wifi
    import wifi_phy_defs::*;
#(
    parameter int DEPTH = TB_DEPTH,
    parameter int AW = TB_AW
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_data,
    input  logic out_ready,
    output logic out_valid,
    output logic out_data,
    output logic out_last,
    output logic overflow,
    output logic busy
);
    rd_state_t state, state_n;
    logic wr_bank, rd_bank, prev_valid;
    logic [AW:0] wr_cnt;
    logic [AW:0] len [2];
    logic [1:0] full, full_n;
    logic [AW-1:0] rd_ptr, rd_ptr_n, rd_addr;
    logic wr_en, close, accept, release_rd, re, rdata;

    assign wr_en = in_valid && !full[wr_bank];
    assign close = (prev_valid && !in_valid && wr_cnt != '0) || (wr_en && wr_cnt == (AW+1)'(DEPTH - 1));
    assign accept = (state == RD_STREAM) && out_ready;
    assign release_rd = accept && rd_ptr == '0;
    assign out_valid = (state == RD_STREAM);
    assign out_last = out_valid && rd_ptr == '0;
    assign out_data = out_valid && rdata;
    assign busy = (|full) || state != RD_IDLE;

    // Close and release always target different banks, so both may apply in one cycle.
    always_comb begin
        full_n = full;
        if (close) full_n[wr_bank] = 1'b1;
        if (release_rd) full_n[rd_bank] = 1'b0;
    end

    // Reads run one address ahead so an accepted bit is replaced without a bubble.
    always_comb begin
        state_n = state;
        rd_ptr_n = rd_ptr;
        rd_addr = rd_ptr;
        re = 1'b0;
        case (state)
            RD_IDLE: if (full[rd_bank]) begin
                state_n = RD_FETCH;
                rd_ptr_n = AW'(len[rd_bank] - 1'b1);
            end
            RD_FETCH: begin
                re = 1'b1;
                state_n = RD_STREAM;
            end
            RD_STREAM: if (accept) begin
                if (rd_ptr != '0) begin
                    re = 1'b1;
                    rd_addr = rd_ptr - 1'b1;
                    rd_ptr_n = rd_ptr - 1'b1;
                end else state_n = RD_IDLE;
            end
            default: state_n = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RD_IDLE;
            rd_ptr <= '0;
            rd_bank <= 1'b0;
            wr_bank <= 1'b0;
            wr_cnt <= '0;
            prev_valid <= 1'b0;
            full <= '0;
            len[0] <= '0;
            len[1] <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            rd_ptr <= rd_ptr_n;
            full <= full_n;
            prev_valid <= in_valid;
            if (in_valid && full[wr_bank]) overflow <= 1'b1;
            if (release_rd) rd_bank <= ~rd_bank;
            if (close) begin
                len[wr_bank] <= wr_en ? wr_cnt + 1'b1 : wr_cnt;
                wr_bank <= ~wr_bank;
                wr_cnt <= '0;
            end else if (wr_en) wr_cnt <= wr_cnt + 1'b1;
        end
    end

    reorder_dpram #(.AW(AW)) u_ram (
        .clk(clk),
        .we(wr_en),
        .waddr({wr_bank, wr_cnt[AW-1:0]}),
        .wdata(in_data),
        .re(re),
        .raddr({rd_bank, rd_addr}),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_viterbi_lifo_reorder_wifi.sv
// Scoreboard bench: each accepted input run is reversed per 64-bit chunk into an expected queue,
// which a negedge monitor drains against the DUT output stream.
module tb_viterbi_lifo_reorder_wifi;
    typedef struct {
        bit d;
        bit l;
        int idx;
        int len;
    } exp_t;

    logic clk, reset, in_valid, in_data, out_ready;
    logic out_valid, out_data, out_last, overflow, busy;
    exp_t exp_q[$];
    int n_cmp = 0, n_fail = 0, cyc = 0, outstanding = 0, ready_mode = 1;
    int blk_start = 0, start_mode = 0, le = 0;
    bit stall_prev = 0, pd = 0, pl = 0;

    viterbi_lifo_reorder_wifi dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .overflow(overflow), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial out_ready = 1;
    always @(posedge clk) begin
        #2;
        out_ready = (ready_mode == 2) ? 1'($urandom % 2) : (ready_mode == 1);
    end

    always @(negedge clk) begin
        if (!reset) stall_prev = 0;
        else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, pd);
                check("hold_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data", out_data, e.d);
                    check("last", out_last, e.l);
                    if (e.idx == 0) begin
                        blk_start = cyc;
                        start_mode = ready_mode;
                    end
                    if (e.l) begin
                        outstanding--;
                        if (ready_mode == 1 && start_mode == 1) check("gap", cyc - blk_start, e.len - 1);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
        end
    end

    // Sends n contiguous bits; each 64-bit chunk (or the tail) is one block, emitted reversed.
    task automatic send_run(input int n, input bit drop, input bit pat, output int last_edge);
        int chunks = (n + 63) / 64;
        int t = 0;
        int cs = 0;
        bit bits[$];
        if (!drop) begin
            while (outstanding + chunks > 2 && t < 2000) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 2000) check("slot_timeout", outstanding, 2 - chunks);
        end
        for (int k = 0; k < n; k++) begin
            int i = n - 1 - k;
            bit b = pat ? bit'(i[0] ^ i[3]) : bit'($urandom % 2);
            in_valid = 1;
            in_data = b;
            bits.push_back(b);
            @(posedge clk); #1;
            if (!drop && ((k + 1) % 64 == 0 || k == n - 1)) begin
                for (int j = k; j >= cs; j--)
                    exp_q.push_back('{d: bits[j], l: (j == cs), idx: k - j, len: k - cs + 1});
                outstanding++;
                cs = k + 1;
            end
        end
        last_edge = cyc;
        in_valid = 0;
        in_data = 0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || outstanding != 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        reset = 0;
        in_valid = 0;
        in_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        reset = 1;
        @(posedge clk); #1;

        send_run(64, 0, 1, le);
        wait_valid();
        check("latency", cyc - le, 2);
        @(posedge clk); #1;
        wait_drain();
        check("t1_busy_idle", busy, 0);

        send_run(10, 0, 0, le);
        wait_drain();

        send_run(128, 0, 0, le);
        wait_drain();
        check("t3_overflow", overflow, 0);

        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_run(64, 0, 0, le);
        send_run(64, 0, 0, le);
        send_run(64, 1, 0, le);
        check("t4_overflow", overflow, 1);
        check("t4_busy", busy, 1);
        ready_mode = 1;
        wait_drain();
        check("t4_overflow_sticky", overflow, 1);

        ready_mode = 2;
        for (int b = 0; b < 8; b++) send_run($urandom_range(1, 64), 0, 0, le);
        wait_drain();
        ready_mode = 1;

        send_run(64, 0, 0, le);
        wait_valid();
        repeat (5) @(posedge clk);
        #1;
        check("t6_streaming", out_valid, 1);
        #2;
        reset = 0;
        exp_q.delete();
        outstanding = 0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_overflow", overflow, 0);
        check("t6_out_last", out_last, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1;
        @(posedge clk); #1;
        send_run(64, 0, 0, le);
        wait_drain();

        send_run(1, 0, 0, le);
        wait_drain();
        check("t7_overflow", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
